multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Control FSM sequencing the shared multi-cycle datapath (one ALU, one memory port, IR/MDR/ALUOut regs).
//  Executes LW SW J JAL JR BNE XORI ADDI ADD SUB SLT in 3-5 states, plus memory wait cycles.
//  Sits between the IR opcode/funct fields and the datapath mux/write-enable controls.
// PARAMETERS
//  MAX_WAIT  15  max consecutive mem_ready=0 cycles in one memory state before mem_timeout sets
//  CNT_W     4   width of wait counter; must hold MAX_WAIT
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  opcode       in   6   IR[31:26], valid from DECODE onward
//  funct        in   6   IR[5:0]
//  mem_ready    in   1   memory completes the access this cycle
//  mem_req      out  1   memory access request; held until mem_ready
//  mem_we       out  1   write (SW); valid with mem_req
//  iord         out  1   0=PC address, 1=ALUOut address
//  irwrite      out  1   load IR
//  pcwrite      out  1   unconditional PC load
//  pcwrite_ne   out  1   PC load if ALU zero==0 (BNE)
//  pcsrc        out  2   00 ALU result, 01 ALUOut, 10 jump target, 11 rs
//  alusrca      out  1   0=PC, 1=rs
//  alusrcb      out  2   00 rt, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
//  extop        out  1   1=sign-extend, 0=zero-extend (XORI only)
//  aluop        out  3   000 ADD, 001 SUB, 010 XOR, 011 SLT
//  regdst       out  2   00 rt, 01 rd, 10 $31
//  memtoreg     out  2   00 ALUOut, 01 MDR, 10 PC
//  regwrite     out  1   register file write
//  mem_timeout  out  1   sticky; MAX_WAIT exceeded
//  state_dbg    out  4   current state encoding
// BEHAVIOUR
//  - Reset (sync, any state, mid-access too): state=FETCH, wait count=0, mem_timeout=0.
//    All outputs are Moore decodes of state, so they take their FETCH values the cycle after reset.
//  - Default for any output not listed in a state: 0. aluop defaults to ADD.
//  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01.
//    If mem_ready: irwrite=1, pcwrite=1, pcsrc=00, go DECODE; else stay.
//  - DECODE: alusrca=0, alusrcb=11, ALUOut<=branch target. Next state by op:
//    LW/SW->MEMADR; R(ADD/SUB/SLT)->EXEC_R; ADDI/XORI->EXEC_I; BNE->BRANCH;
//    J->JUMP; JAL->JAL_WB; R+funct JR->JUMP_REG; else ILLEGAL handling (see CONFIGURATION).
//  - MEMADR: alusrca=1, alusrcb=10, extop=1, ADD; LW->MEMRD, SW->MEMWR.
//  - MEMRD: mem_req=1, iord=1; mem_ready->LW_WB. MEMWR: mem_req=1, mem_we=1, iord=1; mem_ready->FETCH.
//  - LW_WB: regwrite=1, regdst=00, memtoreg=01 ->FETCH.
//  - EXEC_R: alusrca=1, alusrcb=00, aluop from funct ->R_WB (regwrite, regdst=01, memtoreg=00) ->FETCH.
//  - EXEC_I: alusrca=1, alusrcb=10; ADDI: extop=1, ADD; XORI: extop=0, XOR.
//    ->I_WB (regwrite, regdst=00, memtoreg=00) ->FETCH.
//  - BRANCH: alusrca=1, alusrcb=00, SUB, pcwrite_ne=1, pcsrc=01 ->FETCH.
//  - JUMP: pcwrite=1, pcsrc=10. JUMP_REG: pcwrite=1, pcsrc=11.
//    JAL_WB: regwrite=1, regdst=10, memtoreg=10, pcwrite=1, pcsrc=10. All ->FETCH.
//  - Cycles with zero wait: LW 5, SW/R/I 4, BNE/J/JAL/JR 3.
//  - Wait counter: clears on entering any memory state. Increments while mem_req && !mem_ready,
//    saturating at MAX_WAIT. A stall cycle with count==MAX_WAIT sets mem_timeout;
//    the FSM keeps waiting (no abort). Cleared only by reset.
//  - mem_ready while mem_req=0: ignored.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode/funct in DECODE -> TRAP state, all outputs 0;
//    state_dbg=TRAP; held until reset.
//  Not defined: unknown op -> FETCH (NOP); PC already advanced.
// STRUCTURE
//  Package mc_ctrl_pkg: opcode/funct localparams, state encodings (4-bit), aluop/pcsrc/alusrcb/regdst/
//    memtoreg encodings. Shared with the single-cycle instruction decoder.
//  Sub-module mc_op_classify: combinational opcode/funct -> instruction-class one-hot,
//    used by the DECODE next-state logic.
// TESTING
//  ADD (op 0, funct 100000), mem_ready=1: states FETCH,DECODE,EXEC_R,R_WB; regwrite=1, regdst=01 in cycle 4.
//  LW with 3 stall cycles in MEMRD: mem_req held 4 cycles, iord=1; LW_WB memtoreg=01; total 8 cycles.
//  BNE: BRANCH asserts pcwrite_ne=1, aluop=001, pcsrc=01; back in FETCH at cycle 4.
//  JAL: JAL_WB regdst=10, memtoreg=10, pcwrite=1, pcsrc=10.
//    JR (op 0, funct 001000): JUMP_REG pcsrc=11.
//  MAX_WAIT=15, 16 stall cycles in FETCH -> mem_timeout=1 after the 16th stall cycle; stays 1.
//    Reset then clears it and returns to FETCH.
//  Opcode 111111: with ILLEGAL_TRAP_EN state_dbg=TRAP and held; without it, next state is FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and the single-cycle instruction decoder.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWR    = 4'd4,
    S_LW_WB    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JUMP_REG = 4'd12,
    S_JAL_WB   = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_XOR = 3'b010, ALU_SLT = 3'b011} aluop_t;
  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11} pcsrc_t;
  typedef enum logic [1:0] {SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11} alusrcb_t;
  typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} regdst_t;
  typedef enum logic [1:0] {MR_ALU = 2'b00, MR_MDR = 2'b01, MR_PC = 2'b10} memtoreg_t;

  typedef struct packed {
    logic mem;
    logic rtype;
    logic itype;
    logic branch;
    logic jump;
    logic jal;
    logic jr;
    logic illegal;
  } op_class_t;

  function automatic aluop_t funct_aluop(logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs, memory handshake and datapath controls of the multi-cycle controller.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       pcwrite_ne;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [2:0] aluop;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic       regwrite;
  logic       mem_timeout;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, mem_we, iord, irwrite, pcwrite, pcwrite_ne, pcsrc, alusrca, alusrcb,
           extop, aluop, regdst, memtoreg, regwrite, mem_timeout, state_dbg
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, mem_we, iord, irwrite, pcwrite, pcwrite_ne, pcsrc, alusrca, alusrcb,
           extop, aluop, regdst, memtoreg, regwrite, mem_timeout, state_dbg
  );
endinterface

// File: rtl/mc_op_classify.sv
// Opcode/funct to one-hot instruction class, consumed by the DECODE next-state logic.
module mc_op_classify
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OP_LW, OP_SW:     op_class.mem    = 1'b1;
      OP_ADDI, OP_XORI: op_class.itype  = 1'b1;
      OP_BNE:           op_class.branch = 1'b1;
      OP_J:             op_class.jump   = 1'b1;
      OP_JAL:           op_class.jal    = 1'b1;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: op_class.rtype   = 1'b1;
          FN_JR:                  op_class.jr      = 1'b1;
          default:                op_class.illegal = 1'b1;
        endcase
      end
      default:          op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle datapath sequencer with memory wait timeout; ILLEGAL_TRAP_EN makes unknown ops lock in TRAP.
// state      | meaning
// FETCH      | read instruction at PC, PC+4 on mem_ready
// DECODE     | branch target into ALUOut, dispatch on class
// MEMADR     | rs + sign-ext imm address
// MEMRD/WR   | data access at ALUOut, waits on mem_ready
// LW_WB      | MDR -> rt
// EXEC_R/R_WB| R-type ALU op, result -> rd
// EXEC_I/I_WB| immediate ALU op, result -> rt
// BRANCH     | BNE compare, PC <- ALUOut if not zero
// JUMP/JUMP_REG/JAL_WB | PC <- target / rs / target with link
// TRAP       | illegal instruction, held until reset
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  op_class_t        op_class;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             stall, enter_mem;

  mc_op_classify u_classify (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .op_class (op_class)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_FETCH;
        if      (op_class.mem)     state_nxt = S_MEMADR;
        else if (op_class.rtype)   state_nxt = S_EXEC_R;
        else if (op_class.itype)   state_nxt = S_EXEC_I;
        else if (op_class.branch)  state_nxt = S_BRANCH;
        else if (op_class.jump)    state_nxt = S_JUMP;
        else if (op_class.jal)     state_nxt = S_JAL_WB;
        else if (op_class.jr)      state_nxt = S_JUMP_REG;
        else if (op_class.illegal) state_nxt = ILLEGAL_NEXT;
      end
      S_MEMADR: state_nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_nxt = S_LW_WB;
      S_MEMWR:  if (bus.mem_ready) state_nxt = S_FETCH;
      S_EXEC_R: state_nxt = S_R_WB;
      S_EXEC_I: state_nxt = S_I_WB;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.pcwrite_ne = 1'b0;
    bus.pcsrc      = PC_ALU;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = SRCB_RT;
    bus.extop      = 1'b0;
    bus.aluop      = ALU_ADD;
    bus.regdst     = RD_RT;
    bus.memtoreg   = MR_ALU;
    bus.regwrite   = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
        end
      end
      S_DECODE: bus.alusrcb = SRCB_BR;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        bus.extop   = 1'b1;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
      end
      S_LW_WB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = MR_MDR;
      end
      S_EXEC_R: begin
        bus.alusrca = 1'b1;
        bus.aluop   = funct_aluop(bus.funct);
      end
      S_R_WB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = RD_RD;
      end
      S_EXEC_I: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        // XORI zero-extends its immediate, ADDI sign-extends
        if (bus.opcode == OP_XORI) bus.aluop = ALU_XOR;
        else                       bus.extop = 1'b1;
      end
      S_I_WB: bus.regwrite = 1'b1;
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.aluop      = ALU_SUB;
        bus.pcwrite_ne = 1'b1;
        bus.pcsrc      = PC_ALUOUT;
      end
      S_JUMP: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = PC_JUMP;
      end
      S_JUMP_REG: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = PC_RS;
      end
      S_JAL_WB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = RD_RA;
        bus.memtoreg = MR_PC;
        bus.pcwrite  = 1'b1;
        bus.pcsrc    = PC_JUMP;
      end
      default: ;
    endcase
  end

  assign stall     = bus.mem_req && !bus.mem_ready;
  assign enter_mem = (state_nxt != state) && (state_nxt inside {S_FETCH, S_MEMRD, S_MEMWR});

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (stall && (wait_cnt == WAIT_LIMIT)) timeout_q <= 1'b1;
      if (enter_mem)                               wait_cnt <= '0;
      else if (stall && (wait_cnt != WAIT_LIMIT))  wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign bus.mem_timeout = timeout_q;
  assign bus.state_dbg   = state;

endmodule
